// File: rtl/alu_ctrl_mdu.sv
`default_nettype none
// =============================================================================
// Module   : alu_ctrl_mdu
// Purpose  : ALU control decode plus an iterative multiply/divide unit with HI/LO.
// Revision : 1.0 - initial release
// =============================================================================
module alu_ctrl_mdu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [1:0]        aluop,
    input  logic [5:0]        func,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [CTRL_W-1:0] alu_control,
    output logic [1:0]        hilo_sel,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     rs_raw_q, rs_raw_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 is_div_q, is_div_d;
    logic                 div_zero_q, div_zero_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 done_q, done_d;

    logic                 w_md_op, w_mfhi, w_mflo, w_sgn, w_ge;
    logic [WIDTH-1:0]     w_rs_mag, w_rt_mag, w_diff;
    logic [WIDTH:0]       w_add, w_shift;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_md_op = (aluop == 2'b10) && (func[5:2] == 4'b0110);
    assign w_mfhi  = (aluop == 2'b10) && (func == 6'b010000);
    assign w_mflo  = (aluop == 2'b10) && (func == 6'b010010);
    assign w_sgn   = ~func[0];

    // Signed ops iterate on magnitudes; signs are re-applied in FIX.
    assign w_rs_mag = (w_sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_mag = (w_sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign w_add   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, opnd_q});
    assign w_diff  = w_shift[WIDTH-1:0] - opnd_q;
    assign w_prod  = {acc_hi_q, acc_lo_q};

    always_comb begin
        alu_control = '0;
        case (aluop)
            2'b00: alu_control = CTRL_W'(4'b0010);
            2'b01: alu_control = CTRL_W'(4'b0110);
            2'b11: alu_control = CTRL_W'(4'b0001);
            default: begin
                case (func)
                    6'b100000: alu_control = CTRL_W'(4'b0010);
                    6'b100010: alu_control = CTRL_W'(4'b0110);
                    6'b100100: alu_control = CTRL_W'(4'b0000);
                    6'b100101: alu_control = CTRL_W'(4'b0001);
                    6'b100111: alu_control = CTRL_W'(4'b1100);
                    6'b100110: alu_control = CTRL_W'(4'b0011);
                    6'b101010: alu_control = CTRL_W'(4'b0111);
                    default:   alu_control = CTRL_W'(4'b0000);
                endcase
            end
        endcase
    end

    always_comb begin
        hilo_sel = 2'b00;
        if (w_mfhi)      hilo_sel = 2'b01;
        else if (w_mflo) hilo_sel = 2'b10;
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = valid && busy && (w_md_op || w_mfhi || w_mflo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        rs_raw_d   = rs_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid && w_md_op) begin
                    acc_hi_d   = '0;
                    acc_lo_d   = w_rs_mag;
                    opnd_d     = w_rt_mag;
                    rs_raw_d   = rs_val;
                    cnt_d      = '0;
                    is_div_d   = func[1];
                    div_zero_d = (rt_val == '0);
                    neg_res_d  = w_sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_rem_d  = w_sgn && rs_val[WIDTH-1];
                    state_d    = func[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    acc_hi_d = w_add[WIDTH:1];
                    acc_lo_d = {w_add[0], acc_lo_q[WIDTH-1:1]};
                end else if (w_ge) begin
                    acc_hi_d = w_diff;
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = w_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last) begin
                    state_d = S_FIX;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_res_q ? -w_prod : w_prod;
                end else if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = rs_raw_q;
                end else begin
                    lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            rs_raw_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            rs_raw_q   <= rs_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            done_q     <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
`default_nettype none
// =============================================================================
// Module   : tb_alu_ctrl_mdu
// Purpose  : Directed and randomized self-checking bench for alu_ctrl_mdu.
// Revision : 1.0 - initial release
// =============================================================================
module tb_alu_ctrl_mdu;

    localparam int W  = 32;
    localparam int CW = 4;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic          clk = 1'b0;
    logic          rst, valid;
    logic [1:0]    aluop;
    logic [5:0]    func;
    logic [W-1:0]  rs_val, rt_val;
    logic [CW-1:0] alu_control;
    logic [1:0]    hilo_sel;
    logic          stall, busy, done;
    logic [W-1:0]  hi, lo;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_done = 0;
    int            n_exp_done = 0;
    int            done_mark;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;
    logic [5:0]    rf;
    logic [W-1:0]  ra, rb;

    alu_ctrl_mdu #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .aluop(aluop), .func(func),
        .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control),
        .hilo_sel(hilo_sel), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        if (f == 6'b100000) return 4'b0010;
        if (f == 6'b100010) return 4'b0110;
        if (f == 6'b100101) return 4'b0001;
        if (f == 6'b100111) return 4'b1100;
        if (f == 6'b100110) return 4'b0011;
        if (f == 6'b101010) return 4'b0111;
        return 4'b0000;
    endfunction

    function automatic logic [1:0] hilo_ref(input logic [1:0] op, input logic [5:0] f);
        if (op != 2'b10) return 2'b00;
        if (f == F_MFHI) return 2'b01;
        if (f == F_MFLO) return 2'b10;
        return 2'b00;
    endfunction

    // Reference results from plain 64-bit arithmetic.
    task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] h, output logic [W-1:0] l);
        longint          sa, sb;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        h = exp_hi;
        l = exp_lo;
        if (f == F_MULT) begin
            p = longint'(sa * sb);
            {h, l} = p;
        end else if (f == F_MULTU) begin
            p = ua * ub;
            {h, l} = p;
        end else if (b == '0) begin
            l = '1;
            h = a;
        end else if (f == F_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = '0;
            end else begin
                l = W'(sa / sb);
                h = W'(sa % sb);
            end
        end else begin
            l = W'(ua / ub);
            h = W'(ua % ub);
        end
    endtask

    // Issue one MD op, optionally present a follow-up instruction while it runs.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit fol_en, input logic [5:0] fol_f,
                          input logic [W-1:0] fol_a, input logic [W-1:0] fol_b);
        logic [W-1:0] nh, nl;
        logic         fol_stall;
        int           cyc;
        ref_md(f, a, b, nh, nl);
        fol_stall = fol_en && (fol_f[5:2] == 4'b0110 || fol_f == F_MFHI || fol_f == F_MFLO);
        aluop = 2'b10; func = f; rs_val = a; rt_val = b; valid = 1'b1;
        #1;
        check({tag, " issue"}, {stall, busy}, 2'b00);
        @(posedge clk); #1;
        if (fol_en) begin
            func = fol_f; rs_val = fol_a; rt_val = fol_b; valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
        #1;
        for (cyc = 1; cyc <= W + 4; cyc++) begin
            check({tag, " run"}, {busy, stall, hi, lo}, {1'b1, fol_stall, exp_hi, exp_lo});
            if (done === 1'b1) break;
            @(posedge clk); #2;
        end
        check({tag, " latency"}, cyc, W + 1);
        @(posedge clk); #2;
        exp_hi = nh;
        exp_lo = nl;
        n_exp_done++;
        check({tag, " result"}, {busy, done, stall, hi, lo}, {3'b000, nh, nl});
        if (fol_en) check({tag, " fol_sel"}, hilo_sel, hilo_ref(2'b10, fol_f));
        if (!(fol_en && fol_f[5:2] == 4'b0110)) valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; aluop = 2'b00; func = '0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", {busy, done, stall, hi, lo}, '0);
        aluop = 2'b01; #1;
        check("reset_comb_alu", alu_control, 4'b0110);
        aluop = 2'b10; func = F_MFHI; valid = 1'b1; #1;
        check("reset_comb_sel", hilo_sel, 2'b01);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check("post_reset_stall", {stall, busy}, 2'b00);
        valid = 1'b0;

        aluop = 2'b10;
        for (int i = 0; i < 64; i++) begin
            func = 6'(i); #1;
            check("sweep_alu", {func, alu_control}, {6'(i), alu_ref(2'b10, 6'(i))});
            check("sweep_sel", {func, hilo_sel}, {6'(i), hilo_ref(2'b10, 6'(i))});
        end
        func = 6'b100111; #1;
        check("nor_code", alu_control, 4'b1100);
        for (int op = 0; op < 4; op++) begin
            if (op == 2) continue;
            aluop = 2'(op); func = 6'($urandom); #1;
            check("class_alu", alu_control, alu_ref(2'(op), func));
            check("class_sel", hilo_sel, 2'b00);
        end

        aluop = 2'b10; func = F_MULT; rs_val = 32'd5; rt_val = 32'd6; valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("invalid_ignored", {busy, 32'(n_done)}, {1'b0, 32'd0});

        run_md("mult_m3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, '0, '0, '0);
        check("mult_m3x7 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_md("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, '0, '0);
        check("div_m7d2 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_md("divu_7d0", F_DIVU, 32'd7, 32'd0, 1'b0, '0, '0, '0);
        check("divu_7d0 const", {hi, lo}, {32'h0000_0007, 32'hFFFF_FFFF});
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
        check("div_ovf const", {hi, lo}, {32'h0, 32'h8000_0000});
        run_md("div_m5d0", F_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, '0, '0, '0);
        check("div_m5d0 const", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        run_md("multu_mflo", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, F_MFLO, '0, '0);
        run_md("mult_add_fol", F_MULT, 32'd1234, 32'hFFFF_FF00, 1'b1, F_ADD, '0, '0);
        run_md("b2b_first", F_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, F_MULT, 32'hFFFF_0001, 32'd3);
        run_md("b2b_second", F_MULT, 32'hFFFF_0001, 32'd3, 1'b0, '0, '0, '0);

        for (int k = 0; k < 12; k++) begin
            rf = F_MULT | 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (k % 4 == 1) rb = -rb;
            run_md("random", rf, ra, rb, (k % 5 == 2), F_MFHI, '0, '0);
        end

        aluop = 2'b10; func = F_DIV; rs_val = 32'd1234; rt_val = 32'd5; valid = 1'b1;
        @(posedge clk); #2;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_state", {busy, done, hi, lo}, '0);
        done_mark = n_done;
        repeat (W + 5) @(posedge clk);
        #2;
        check("abort_no_done", {busy, 32'(n_done)}, {1'b0, 32'(done_mark)});
        run_md("divu_100d7", F_DIVU, 32'd100, 32'd7, 1'b0, '0, '0, '0);
        check("divu_100d7 const", {hi, lo}, {32'd2, 32'd14});

        check("done_pulse_count", n_done, n_exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Parameters
REQ-001 The block SHALL take parameter WIDTH, default 32, the operand width; legal range 8..64, even.
REQ-002 The block SHALL take parameter CTRL_W, default 4, the width of alu_control.

Interface
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 valid  input  1  the current aluop/func/operands form a valid instruction this cycle.
REQ-006 aluop  input  2  main-decoder class: 00 add, 01 sub, 10 R-type (decode func), 11 or.
REQ-007 func  input  6  R-type function field.
REQ-008 rs_val, rt_val  input  WIDTH  operands for multiply/divide.
REQ-009 alu_control  output  CTRL_W  ALU operation code.
REQ-010 hilo_sel  output  2  result mux select: 00 ALU, 01 HI, 10 LO.
REQ-011 stall  output  1  CPU shall hold the current instruction.
REQ-012 busy  output  1  multiply/divide unit is active.
REQ-013 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-014 hi, lo  output  WIDTH  HI/LO result registers.

Function
REQ-015 alu_control SHALL be combinational: aluop 00->0010, 01->0110, 11->0001; aluop 10 decodes func 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100 (nor), 100110->0011 (xor), 101010->0111; all other func->0000.
REQ-016 hilo_sel SHALL be 01 for aluop 10 with func 010000 (MFHI), 10 for func 010010 (MFLO), else 00; it is combinational.
REQ-017 MD ops: func 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, only with aluop 10.
REQ-018 FSM states: IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-019 IDLE: valid and MD op -> capture operands and signedness, clear the counter, go to MUL or DIV; the MD instruction itself does not stall.
REQ-020 MUL: one shift-add step per cycle; DIV: one restoring-divide step per cycle; after exactly WIDTH steps go to FIX.
REQ-021 FIX: apply sign correction, write HI/LO, pulse done, return to IDLE; latency from acceptance edge to done is WIDTH+1 cycles.
REQ-022 Signed ops SHALL operate on magnitudes: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-023 MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. DIV/DIVU: lo = quotient, hi = remainder.
REQ-024 Divide by zero: lo = all ones, hi = rs_val as captured; full latency still applies.
REQ-025 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
REQ-026 busy SHALL be 1 in MUL, DIV and FIX; 0 in IDLE.
REQ-027 stall SHALL be combinational: valid and busy and (MD op or MFHI or MFLO); no other case stalls.
REQ-028 An MD op arriving while busy SHALL be stalled, not queued; it is accepted on the first cycle FSM is IDLE.
REQ-029 hi/lo SHALL hold their previous values throughout an operation and change only in FIX.
REQ-030 An MD op with valid low SHALL be ignored.
REQ-031 An MFHI/MFLO in the same cycle as done SHALL stall (busy is still 1); it reads the new value the next cycle.

Reset
REQ-032 rst SHALL force IDLE, counter 0, hi=0, lo=0, done=0, busy=0, and take priority over all other inputs.
REQ-033 rst during MUL/DIV/FIX SHALL abort the operation with no done pulse and no HI/LO update.
REQ-034 Combinational outputs (alu_control, hilo_sel) SHALL follow inputs during reset; stall SHALL be 0 in the first cycle after reset.

Verification (WIDTH=32)
REQ-035 aluop=10 sweep over all 64 func values, plus aluop 00/01/11 -> codes per REQ-015; func 100111 -> 1100.
REQ-036 MULT rs=-3, rt=7 -> done exactly 33 cycles after acceptance; hi=FFFFFFFF, lo=FFFFFFEB; busy high for those 33 cycles.
REQ-037 DIV rs=-7, rt=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU rs=7, rt=0 -> lo=FFFFFFFF, hi=00000007.
REQ-038 MULTU then MFLO issued next cycle -> stall held until the cycle after done; MFLO then sees new lo, hilo_sel=10.
REQ-039 Back-to-back MULT, MULT -> second stalled, accepted the cycle FSM returns to IDLE; no lost or duplicated done.
REQ-040 rst asserted at step 10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse; a new DIVU 100/7 then gives lo=14, hi=2.
